compute_z: RTL
==============

Name: compute_z

Overview:
Inverse-direction companion to the variant-1 function unit: computes z = floor(a^(1/2)) + b^3 on unsigned operands.
- Square root is the inverse of the squaring path; cube is the inverse of the cube-root path.
- Resources: one shared shift-add multiplier (used twice: b*b, then b^2*b), one digit-by-digit square-root engine, one final adder.
- Sits beside the existing function unit on the same start/busy_o handshake so the system FSM can drive either block.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 4.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  square-root operand, unsigned
b  input  WIDTH  cube operand, unsigned
z  output  WIDTH  result; held until next completion
busy_o  output  1  high while a computation is in progress
done_o  output  1  one-cycle pulse on the edge z is written
ovf_o  output  1  set with done_o when the exact z exceeds 2^WIDTH-1; held until next start

Behaviour:
- Reset (async, any state): state=IDLE; z=0, busy_o=0, done_o=0, ovf_o=0; all internal registers 0.
- Any computation in flight is abandoned on reset; no done_o is issued.
- States and transitions:
  - IDLE: on start=1, latch a and b, clear the internal registers and ovf_o, set busy_o=1, go to SQRT. With start=0, stay.
  - SQRT: WIDTH/2 cycles of restoring digit-by-digit square root.
    - Each cycle: rem = (rem<<2) | next two MSBs of a; trial = (root<<2)|1.
    - If rem >= trial: rem -= trial, root = (root<<1)|1. Otherwise root <<= 1.
    - Result is floor(sqrt(a)), WIDTH/2 bits wide.
  - MUL1: WIDTH cycles, shift-add b*b, one multiplier bit per cycle, LSB first. The full 2*WIDTH-bit product is kept.
  - MUL2: WIDTH cycles, shift-add (b^2)*b. The product is kept to 3*WIDTH bits internally so overflow is known exactly.
  - SUM: one cycle.
    - sum = root + cube, computed wide.
    - ovf_o = (sum > 2^WIDTH-1).
    - z = result per the Optional Feature.
    - done_o=1, busy_o=0, go to IDLE.
- Latency: the start-sampling edge is edge 0. z and done_o update on edge 1 + WIDTH/2 + 2*WIDTH (edge 21 for WIDTH=8). busy_o is high for exactly that many cycles.
- done_o is high for one cycle only. It is low in every other cycle.
- start while busy_o=1 is ignored; the operands latched at start are used throughout.
- start held high across completion: the block returns to IDLE on the SUM edge and restarts on the next edge. Back-to-back operation therefore has a one-cycle IDLE gap.
- Operands a and b may change freely after the start-sampling edge.
- Default state encoding: any illegal state goes to IDLE with busy_o=0.

Optional Feature:
- Macro: COMPUTE_Z_SAT_EN.
- Defined: on overflow, z saturates to 2^WIDTH-1.
- Undefined: z = sum mod 2^WIDTH (wrap).
- ovf_o reports overflow in both builds. Latency is identical in both builds.

Test Plan:
- a=16, b=2 -> after 21 cycles z=12 (4+8), done_o pulses once, ovf_o=0, busy_o high exactly 21 cycles.
- a=255, b=6 -> z=231 (15+216), ovf_o=0; a=0, b=0 -> z=0, done_o still pulses.
- a=200, b=7 (14+343=357) -> ovf_o=1; z=101 without COMPUTE_Z_SAT_EN, z=255 with it.
- start re-pulsed at cycle 5 with a=1, b=1 during an a=16, b=2 run -> ignored; z=12, then IDLE.
- rst asserted asynchronously mid-MUL2 -> busy_o, z, done_o and ovf_o drop to 0 immediately, no done_o afterwards. A new start with a=9, b=3 then gives z=30.
- start held high continuously with a=4, b=1 -> results z=3 repeat every 22 cycles, each with a single done_o pulse.

Source files
------------

// File: rtl/compute_z.sv
// compute_z: multi-cycle unit producing z = floor(sqrt(a)) + b^3 on unsigned
// operands, using a restoring digit-by-digit square-root engine, one
// shift-add multiplier used twice (b*b, then b^2*b) and a final wide adder.
//
// Configuration macro: COMPUTE_Z_SAT_EN
//   defined   -> z saturates to 2^WIDTH-1 on overflow
//   undefined -> z wraps (sum mod 2^WIDTH)
//   ovf_o reports overflow in both builds; latency is identical.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only while idle
//   a      - square-root operand (WIDTH bits, unsigned)
//   b      - cube operand (WIDTH bits, unsigned)
//   z      - result, held until the next completion
//   busy_o - high while a computation is in progress
//   done_o - one-cycle pulse on the edge z is written
//   ovf_o  - exact result exceeded 2^WIDTH-1; held until next start
//
// Latency: start sampled on edge 0, z/done_o written on edge
// 1 + WIDTH/2 + 2*WIDTH.

module compute_z #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 1;
  localparam int PW = 3 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQRT = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_SUM  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  // Combinational helpers for the datapath stages.
  logic [RW+1:0]    rem_sh;
  logic [RW+1:0]    trial;
  logic [PW-1:0]    acc_add;
  logic [PW:0]      sum;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath logic. The remainder only ever needs HW+1 bits
  // (it never exceeds 2*root); the two extra bits exist only during the
  // shift-and-compare of each root digit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_d      = b_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    z_d      = z_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    rem_sh  = {rem_q, a_sh_q[WIDTH-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);
    sum     = {1'b0, acc_q} + {{(PW + 1 - HW){1'b0}}, root_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_d      = b;
          rem_d    = '0;
          root_d   = '0;
          cnt_d    = '0;
          mcand_d  = '0;
          mplier_d = '0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SQRT;
        end
      end

      S_SQRT: begin
        a_sh_d = {a_sh_q[WIDTH-3:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = RW'(rem_sh - trial);
          root_d = {root_q[HW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[RW-1:0];
          root_d = {root_q[HW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HW - 1)) begin
          cnt_d    = '0;
          mcand_d  = {{(PW - WIDTH){1'b0}}, b_q};
          mplier_d = b_q;
          acc_d    = '0;
          state_d  = S_MUL1;
        end
      end

      S_MUL1: begin
        acc_d    = acc_add;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        // The completed square becomes the multiplicand for the cube pass.
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d    = '0;
          mcand_d  = acc_add;
          mplier_d = b_q;
          acc_d    = '0;
          state_d  = S_MUL2;
        end
      end

      S_MUL2: begin
        acc_d    = acc_add;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_SUM;
        end
      end

      S_SUM: begin
        ovf_d = |sum[PW:WIDTH];
`ifdef COMPUTE_Z_SAT_EN
        z_d = ovf_d ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        z_d = sum[WIDTH-1:0];
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign z      = z_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule
